// File: rtl/seven_seg_readback.sv
// -----------------------------------------------------------------------------
// seven_seg_readback
// Receive side of the 2-digit multiplexed 7-segment display bus. The segment
// and anode lines are synchronised, a pattern must sit unchanged for
// STABLE_CYCLES samples before it is trusted, and the qualified pattern is
// decoded back into a BCD score for the digit whose anode is active.
//
// Optional feature macro: SEVEN_SEG_READBACK_TIMEOUT_EN
//   When defined, each digit's valid bit drops after TIMEOUT_CYCLES without a
//   legal qualified capture of that digit (the BCD value is kept).
//
// Segment patterns are compared as written in the decode table below, as the
// literal 7-bit value seen on seg_i (active-low, 1111111 = blank).
// -----------------------------------------------------------------------------
module seven_seg_readback #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [6:0] seg_i,
    input  logic [1:0] an_i,
    output logic [3:0] score1_bcd_o,
    output logic [3:0] score2_bcd_o,
    output logic       score1_valid_o,
    output logic       score2_valid_o,
    output logic       update_o,
    output logic       decode_err_o
);

    localparam int CNT_W = ($clog2(STABLE_CYCLES) < 1) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SEVEN_SEG_READBACK_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_QUAL = 2'd1,
        S_LOCK = 2'd2
    } stateT;

    // Two-flop synchronisers plus the previous synced sample for change detect
    logic [6:0] segS1_q, segS2_q;
    logic [1:0] anS1_q, anS2_q;
    logic [8:0] prevSample_q;

    stateT            state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] score1Bcd_q, score1Bcd_d;
    logic [3:0] score2Bcd_q, score2Bcd_d;
    logic       score1Valid_q, score1Valid_d;
    logic       score2Valid_q, score2Valid_d;
    logic       update_q, update_d;
    logic       decodeErr_q, decodeErr_d;

`ifdef SEVEN_SEG_READBACK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo1_q, tmo1_d;
    logic [TMO_W-1:0] tmo2_q, tmo2_d;
`endif

    logic [8:0] sample;
    logic       changed;
    logic       anOneHot;
    logic       capture;
    logic       selDigit1;
    logic       patLegal;
    logic [3:0] patDigit;

    // Map a qualified segment pattern to {legal, digit}
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0_0000;
        case (seg)
            7'b0000001: res = 5'b1_0000;
            7'b1001111: res = 5'b1_0001;
            7'b0010010: res = 5'b1_0010;
            7'b0000110: res = 5'b1_0011;
            7'b1001100: res = 5'b1_0100;
            7'b0100100: res = 5'b1_0101;
            7'b0100000: res = 5'b1_0110;
            7'b0001111: res = 5'b1_0111;
            7'b0000000: res = 5'b1_1000;
            7'b0000100: res = 5'b1_1001;
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    assign sample    = {anS2_q, segS2_q};
    assign changed   = (sample != prevSample_q);
    assign anOneHot  = (anS2_q == 2'b10) || (anS2_q == 2'b01);
    assign selDigit1 = (anS2_q == 2'b10);
    assign {patLegal, patDigit} = decodeSeg(segS2_q);

    // Synchronise the bus and remember last cycle's synced sample
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            segS1_q      <= '0;
            segS2_q      <= '0;
            anS1_q       <= '0;
            anS2_q       <= '0;
            prevSample_q <= '0;
        end else begin
            segS1_q      <= seg_i;
            segS2_q      <= segS1_q;
            anS1_q       <= an_i;
            anS2_q       <= anS1_q;
            prevSample_q <= sample;
        end
    end

    // Qualification state and stability counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the cycle in which a new pattern first appears counts
    // as sample zero, so the qualifying sample count is cnt + 1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (anOneHot) begin
                    state_d = S_QUAL;
                    cnt_d   = CNT_ONE;
                end
            end
            S_QUAL: begin
                if (changed) begin
                    if (anOneHot) begin
                        cnt_d = CNT_ONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = S_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOCK: begin
                if (changed) begin
                    if (anOneHot) begin
                        state_d = S_QUAL;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Score registers, valid bits, pulses and (optionally) staleness timers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            score1Bcd_q   <= '0;
            score2Bcd_q   <= '0;
            score1Valid_q <= 1'b0;
            score2Valid_q <= 1'b0;
            update_q      <= 1'b0;
            decodeErr_q   <= 1'b0;
`ifdef SEVEN_SEG_READBACK_TIMEOUT_EN
            tmo1_q        <= '0;
            tmo2_q        <= '0;
`endif
        end else begin
            score1Bcd_q   <= score1Bcd_d;
            score2Bcd_q   <= score2Bcd_d;
            score1Valid_q <= score1Valid_d;
            score2Valid_q <= score2Valid_d;
            update_q      <= update_d;
            decodeErr_q   <= decodeErr_d;
`ifdef SEVEN_SEG_READBACK_TIMEOUT_EN
            tmo1_q        <= tmo1_d;
            tmo2_q        <= tmo2_d;
`endif
        end
    end

    // Capture handling; staleness is applied first so a same-cycle capture wins
    always_comb begin
        score1Bcd_d   = score1Bcd_q;
        score2Bcd_d   = score2Bcd_q;
        score1Valid_d = score1Valid_q;
        score2Valid_d = score2Valid_q;
        update_d      = 1'b0;
        decodeErr_d   = 1'b0;
`ifdef SEVEN_SEG_READBACK_TIMEOUT_EN
        tmo1_d = (tmo1_q == TMO_LAST) ? tmo1_q : tmo1_q + TMO_W'(1);
        tmo2_d = (tmo2_q == TMO_LAST) ? tmo2_q : tmo2_q + TMO_W'(1);
        if (tmo1_q == TMO_LAST) begin
            score1Valid_d = 1'b0;
        end
        if (tmo2_q == TMO_LAST) begin
            score2Valid_d = 1'b0;
        end
`endif
        if (capture) begin
            if (patLegal) begin
                if (selDigit1) begin
                    score1Bcd_d   = patDigit;
                    score1Valid_d = 1'b1;
                    update_d      = (patDigit != score1Bcd_q) || !score1Valid_q;
`ifdef SEVEN_SEG_READBACK_TIMEOUT_EN
                    tmo1_d        = '0;
`endif
                end else begin
                    score2Bcd_d   = patDigit;
                    score2Valid_d = 1'b1;
                    update_d      = (patDigit != score2Bcd_q) || !score2Valid_q;
`ifdef SEVEN_SEG_READBACK_TIMEOUT_EN
                    tmo2_d        = '0;
`endif
                end
            end else begin
                decodeErr_d = 1'b1;
                if (selDigit1) begin
                    score1Valid_d = 1'b0;
                end else begin
                    score2Valid_d = 1'b0;
                end
            end
        end
    end

    assign score1_bcd_o   = score1Bcd_q;
    assign score2_bcd_o   = score2Bcd_q;
    assign score1_valid_o = score1Valid_q;
    assign score2_valid_o = score2Valid_q;
    assign update_o       = update_q;
    assign decode_err_o   = decodeErr_q;

endmodule

// File: tb/tb_seven_seg_readback.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_readback
// Directed bench for the 7-segment readback monitor. Small STABLE/TIMEOUT
// values keep runs short. A table of hold-and-check vectors walks the main
// decode/update/error behaviour; hand-written sequences cover exact latency,
// glitch restart, mid-run reset and digit staleness.
// -----------------------------------------------------------------------------
module tb_seven_seg_readback;

    localparam int STABLE  = 8;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       resetN;
    logic [6:0] segIn;
    logic [1:0] anIn;
    logic [3:0] score1Bcd, score2Bcd;
    logic       score1Valid, score2Valid;
    logic       update, decodeErr;

    int compared   = 0;
    int mismatched = 0;
    int updCount   = 0;
    int errCount   = 0;
    int bothCount  = 0;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        int         cycles;
        logic [3:0] bcd1;
        logic       v1;
        logic [3:0] bcd2;
        logic       v2;
        int         upd;
        int         err;
    } vecT;

    vecT vecs[12];

    seven_seg_readback #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (resetN),
        .seg_i         (segIn),
        .an_i          (anIn),
        .score1_bcd_o  (score1Bcd),
        .score2_bcd_o  (score2Bcd),
        .score1_valid_o(score1Valid),
        .score2_valid_o(score2Valid),
        .update_o      (update),
        .decode_err_o  (decodeErr)
    );

    always #5 clk = ~clk;

    // Compare one value and log a failure line when it differs
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Let n clocks pass, sampling the pulse outputs 1ns after each edge
    task automatic holdCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (update) updCount++;
            if (decodeErr) errCount++;
            if (update && decodeErr) bothCount++;
        end
    endtask

    // Drive a new {an,seg} on the falling edge and hold it for n clocks
    task automatic applyStimulus(input logic [1:0] an, input logic [6:0] seg, input int n);
        @(negedge clk);
        anIn  = an;
        segIn = seg;
        holdCycles(n);
    endtask

    task automatic clearPulseCounts();
        updCount = 0;
        errCount = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " score1_bcd"}, score1Bcd, 0);
        checkOutput({tag, " score2_bcd"}, score2Bcd, 0);
        checkOutput({tag, " score1_valid"}, score1Valid, 0);
        checkOutput({tag, " score2_valid"}, score2Valid, 0);
        checkOutput({tag, " update"}, update, 0);
        checkOutput({tag, " decode_err"}, decodeErr, 0);
    endtask

    initial begin
        // an, seg, hold, bcd1, v1, bcd2, v2, updates, errors
        vecs[0]  = '{2'b10, 7'b0010010, STABLE + 2, 4'd2, 1'b1, 4'd0, 1'b0, 1, 0};
        vecs[1]  = '{2'b01, 7'b0001111, 2 * STABLE, 4'd2, 1'b1, 4'd7, 1'b1, 1, 0};
        vecs[2]  = '{2'b10, 7'b0000110, 2 * STABLE, 4'd3, 1'b1, 4'd7, 1'b1, 1, 0};
        vecs[3]  = '{2'b01, 7'b0001111, 2 * STABLE, 4'd3, 1'b1, 4'd7, 1'b1, 0, 0};
        vecs[4]  = '{2'b10, 7'b0000110, 2 * STABLE, 4'd3, 1'b1, 4'd7, 1'b1, 0, 0};
        vecs[5]  = '{2'b01, 7'b1111111, 2 * STABLE, 4'd3, 1'b1, 4'd7, 1'b0, 0, 1};
        vecs[6]  = '{2'b00, 7'b0000000, 3 * STABLE, 4'd3, 1'b1, 4'd7, 1'b0, 0, 0};
        vecs[7]  = '{2'b01, 7'b0001111, 2 * STABLE, 4'd3, 1'b1, 4'd7, 1'b1, 1, 0};
        vecs[8]  = '{2'b10, 7'b0000000, 2 * STABLE, 4'd8, 1'b1, 4'd7, 1'b1, 1, 0};
        vecs[9]  = '{2'b11, 7'b0000001, 2 * STABLE, 4'd8, 1'b1, 4'd7, 1'b1, 0, 0};
        vecs[10] = '{2'b10, 7'b1010101, 2 * STABLE, 4'd8, 1'b0, 4'd7, 1'b1, 0, 1};
        vecs[11] = '{2'b10, 7'b0000001, 2 * STABLE, 4'd0, 1'b1, 4'd7, 1'b1, 1, 0};

        // Power-on reset with a blank bus
        resetN = 1'b0;
        anIn   = 2'b11;
        segIn  = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("por");
        @(negedge clk);
        resetN = 1'b1;

        // Table of hold-and-check vectors; state carries from one to the next
        for (int v = 0; v < 12; v++) begin
            clearPulseCounts();
            applyStimulus(vecs[v].an, vecs[v].seg, vecs[v].cycles);
            checkOutput($sformatf("vec%0d score1_bcd", v), score1Bcd, vecs[v].bcd1);
            checkOutput($sformatf("vec%0d score1_valid", v), score1Valid, vecs[v].v1);
            checkOutput($sformatf("vec%0d score2_bcd", v), score2Bcd, vecs[v].bcd2);
            checkOutput($sformatf("vec%0d score2_valid", v), score2Valid, vecs[v].v2);
            checkOutput($sformatf("vec%0d update pulses", v), updCount, vecs[v].upd);
            checkOutput($sformatf("vec%0d decode_err pulses", v), errCount, vecs[v].err);
        end

        // Glitch: 9 held only STABLE-2 clocks, then 6 needs a full fresh window
        clearPulseCounts();
        applyStimulus(2'b10, 7'b0000100, STABLE - 2);
        applyStimulus(2'b10, 7'b0100000, STABLE + 1);
        checkOutput("glitch early update", updCount, 0);
        checkOutput("glitch early score1_bcd", score1Bcd, 0);
        holdCycles(1);
        checkOutput("glitch update", updCount, 1);
        checkOutput("glitch score1_bcd", score1Bcd, 6);
        checkOutput("glitch score1_valid", score1Valid, 1);

        // Reset mid-qualification, then a full window after release
        applyStimulus(2'b01, 7'b0000110, STABLE - 2);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        clearPulseCounts();
        holdCycles(STABLE + 1);
        checkOutput("postreset early update", updCount, 0);
        checkOutput("postreset early score2_valid", score2Valid, 0);
        holdCycles(1);
        checkOutput("postreset update", updCount, 1);
        checkOutput("postreset score2_bcd", score2Bcd, 3);
        checkOutput("postreset score2_valid", score2Valid, 1);

        // Staleness: capture digit 1, then only drive digit 2 for a long time
        clearPulseCounts();
        applyStimulus(2'b10, 7'b0000100, 2 * STABLE);
        checkOutput("stale setup score1_bcd", score1Bcd, 9);
        checkOutput("stale setup score1_valid", score1Valid, 1);
        clearPulseCounts();
        applyStimulus(2'b01, 7'b0000110, TIMEOUT + 20);
        checkOutput("stale score1_bcd held", score1Bcd, 9);
        checkOutput("stale score2_bcd held", score2Bcd, 3);
        checkOutput("stale update pulses", updCount, 0);
        checkOutput("stale decode_err pulses", errCount, 0);
`ifdef SEVEN_SEG_READBACK_TIMEOUT_EN
        checkOutput("stale score1_valid", score1Valid, 0);
        checkOutput("stale score2_valid", score2Valid, 0);
`else
        checkOutput("stale score1_valid", score1Valid, 1);
        checkOutput("stale score2_valid", score2Valid, 1);
`endif

        checkOutput("update/decode_err exclusive", bothCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
